booth_mac_accum: RTL and testbench
==================================

// Module: booth_mac_accum
// PURPOSE
//  Downstream consumer of the 16x16 signed Booth multiplier's 32-bit products.
//  Accumulates a frame of LEN products into a wide signed accumulator.
//  Accepts products over a valid/ready handshake.
//  Presents the frame sum over a valid/ready handshake to the next stage (FIR/dot-product use).
// PARAMETERS
//  PROD_W   32  product width, two's complement, sign-extended into accumulator
//  ACC_W    40  accumulator/result width (must be >= PROD_W)
//  CNT_W    8   width of frame-length field; max frame = 2**CNT_W-1 products
// PORTS
//  clk         in   1       single clock; all state updates on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       begin frame; sampled only in IDLE
//  len         in   CNT_W   products in frame; latched on accepted start
//  abort       in   1       drop current frame, return to IDLE
//  prod        in   PROD_W  signed product from multiplier
//  prod_valid  in   1       prod is valid this cycle
//  prod_ready  out  1       block accepts prod this cycle
//  acc         out  ACC_W   signed frame sum; stable while acc_valid=1
//  acc_valid   out  1       result available
//  acc_ready   in   1       downstream takes result
//  busy        out  1       state != IDLE
//  ovf         out  1       sticky per-frame overflow flag (macro only, else tied 0)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE; acc=0, cnt=0, ovf=0.
//   - prod_ready=0, acc_valid=0, busy=0.
//  FSM states: IDLE, ACCUM, DONE.
//  IDLE: start=1 -> acc<=0, ovf<=0, cnt<=len.
//   - len!=0 -> ACCUM.
//   - len==0 -> DONE with acc=0.
//  ACCUM: prod_ready=1.
//   - Transfer = prod_valid & prod_ready.
//   - Each transfer: acc <= acc + sext(prod); cnt <= cnt-1.
//   - Transfer with cnt==1 -> DONE.
//   - No transfer -> hold state.
//  DONE: acc_valid=1, prod_ready=0.
//   - acc_ready=1 -> IDLE next cycle.
//   - Otherwise hold acc/acc_valid indefinitely.
//  Latency: acc_valid rises the cycle after the last product transfer; back-to-back transfers sustain 1 product/cycle.
//  start outside IDLE: ignored, not queued. A new frame may start no earlier than the first IDLE cycle after handoff.
//  abort (ACCUM or DONE): -> IDLE next cycle; acc, ovf, cnt cleared; no acc_valid pulse.
//   - abort beats prod transfer and acc_ready in the same cycle.
//   - abort in IDLE: no effect; start is not accepted that cycle.
//  Outputs are registered; prod_ready/acc_valid/busy are decoded from state register only.
//  Arithmetic: full-width two's-complement add of ACC_W bits; sign-extend prod from PROD_W.
// CONFIGURATION
//  BOOTH_MAC_SAT_EN defined:
//   - Sum exceeding signed ACC_W range clamps to 2**(ACC_W-1)-1 or -2**(ACC_W-1).
//   - ovf set and held until next accepted start, abort or reset.
//   - Further products still add from the clamped value.
//  BOOTH_MAC_SAT_EN undefined:
//   - acc wraps modulo 2**ACC_W.
//   - ovf output tied 0; no saturation logic.
// TESTING
//  1 Reset mid-ACCUM (after 2 products): all outputs 0 immediately, state IDLE; next frame unaffected.
//  2 len=4, prods -29952,-296712,422640,85888 back-to-back -> acc=181864, acc_valid 1 cycle after 4th transfer.
//  3 Same frame with prod_valid gaps and acc_ready held 0 for 5 cycles -> acc stable at 181864, prod_ready=0 in DONE.
//  4 len=0 start -> DONE next cycle with acc=0; start pulsed during DONE ignored.
//  5 abort after 2 of 4 products -> IDLE, no acc_valid; next frame len=1, prod=-7 -> acc=-7.
//  6 ACC_W=34, len=8, prod=2**30 each:
//   - BOOTH_MAC_SAT_EN: acc=8589934591, ovf=1.
//   - Macro undefined: acc=-8589934592, ovf=0.

Source files
------------

// File: rtl/booth_mac_accum.sv
// -----------------------------------------------------------------------------
// booth_mac_accum
//
// Purpose:
//   Frame accumulator that sits behind the 16x16 signed Booth multiplier.
//   A frame of `len` signed products is summed into a wide signed accumulator.
//   The frame sum is then handed to the next stage (FIR / dot-product).
//   Products arrive over a valid/ready handshake and the result leaves over
//   another valid/ready handshake.
//
// Optional feature (compile-time macro):
//   BOOTH_MAC_SAT_EN  - when defined, the accumulator saturates to the signed
//                       ACC_W range and raises a sticky per-frame `ovf` flag.
//                       When undefined, the accumulator wraps modulo 2**ACC_W
//                       and `ovf` is tied low.
//
// Parameters:
//   PROD_W  product width (two's complement), sign-extended into the accumulator
//   ACC_W   accumulator / result width, must be >= PROD_W
//   CNT_W   frame-length field width; max frame = 2**CNT_W-1 products
//
// Ports:
//   clk         in   1       single clock, posedge
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       begin a frame (sampled only in IDLE)
//   len         in   CNT_W   products in frame, latched on accepted start
//   abort       in   1       drop current frame, return to IDLE
//   prod        in   PROD_W  signed product from multiplier
//   prod_valid  in   1       prod is valid this cycle
//   prod_ready  out  1       block accepts prod this cycle (ACCUM state)
//   acc         out  ACC_W   signed frame sum, stable while acc_valid=1
//   acc_valid   out  1       result available (DONE state)
//   acc_ready   in   1       downstream takes the result
//   busy        out  1       state != IDLE
//   ovf         out  1       sticky per-frame overflow (saturating build only)
// -----------------------------------------------------------------------------
module booth_mac_accum #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         len,
  input  logic                     abort,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic                     busy,
  output logic                     ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

`ifdef BOOTH_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                     ovf_q, ovf_d;
  logic signed [ACC_W:0]    sum_ext;

  // One guard bit above the accumulator: the sum of an in-range accumulator
  // and a sign-extended product can never overflow ACC_W+1 bits, so the two
  // top bits disagreeing is an exact overflow test.
  function automatic logic signed [ACC_W:0] add_ext(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [PROD_W-1:0] p
  );
    return (ACC_W+1)'(a) + (ACC_W+1)'(p);
  endfunction

  function automatic logic sum_ovf(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  // Clamp toward the sign of the true (guard-bit) result.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] s);
    logic signed [ACC_W-1:0] r;
    if (sum_ovf(s)) begin
      r = s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      r = s[ACC_W-1:0];
    end
    return r;
  endfunction
`else
  // Plain two's-complement add; the carry out of ACC_W is simply dropped.
  function automatic logic signed [ACC_W-1:0] add_wrap(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [PROD_W-1:0] p
  );
    return a + ACC_W'(p);
  endfunction
`endif

  // Handshake/status outputs decode the state register only, so they are
  // glitch-free and carry no combinational path from the inputs.
  assign prod_ready = (state_q == S_ACCUM);
  assign acc_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign acc        = acc_q;

`ifdef BOOTH_MAC_SAT_EN
  assign ovf        = ovf_q;
  assign sum_ext    = add_ext(acc_q, prod);
`else
  assign ovf        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef BOOTH_MAC_SAT_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        // abort in IDLE blocks a same-cycle start.
        if (start && !abort) begin
          acc_d   = '0;
          cnt_d   = len;
`ifdef BOOTH_MAC_SAT_EN
          ovf_d   = 1'b0;
`endif
          // An empty frame goes straight to DONE with a zero sum.
          state_d = (len != '0) ? S_ACCUM : S_DONE;
        end
      end

      S_ACCUM: begin
        if (abort) begin
          acc_d   = '0;
          cnt_d   = '0;
`ifdef BOOTH_MAC_SAT_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_IDLE;
        end else if (prod_valid) begin
`ifdef BOOTH_MAC_SAT_EN
          acc_d = sat(sum_ext);
          if (sum_ovf(sum_ext)) begin
            ovf_d = 1'b1;
          end
`else
          acc_d = add_wrap(acc_q, prod);
`endif
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // abort wins over a simultaneous acc_ready: no handoff happens.
        if (abort) begin
          acc_d   = '0;
          cnt_d   = '0;
`ifdef BOOTH_MAC_SAT_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_IDLE;
        end else if (acc_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef BOOTH_MAC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef BOOTH_MAC_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// -----------------------------------------------------------------------------
// tb_booth_mac_accum
//   Directed bench for booth_mac_accum with ACC_W=34 so that the overflow
//   frame (8 x 2**30) reaches the accumulator range limit. Inputs change 1ns
//   after each rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_booth_mac_accum;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 34;
  localparam int CNT_W  = 8;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [CNT_W-1:0]         len;
  logic                     abort;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_valid;
  logic                     acc_ready;
  logic                     busy;
  logic                     ovf;

  int checks = 0;
  int errors = 0;

  booth_mac_accum #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .acc       (acc),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic signed [PROD_W-1:0] p);
    prod       = p;
    prod_valid = 1'b1;
    step();
  endtask

  task automatic idle_in();
    prod_valid = 1'b0;
    step();
  endtask

  logic signed [63:0] exp6_acc;
  logic               exp6_ovf;

  initial begin
`ifdef BOOTH_MAC_SAT_EN
    exp6_acc = 64'sd8589934591;
    exp6_ovf = 1'b1;
`else
    exp6_acc = -64'sd8589934592;
    exp6_ovf = 1'b0;
`endif

    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    abort      = 1'b0;
    prod       = '0;
    prod_valid = 1'b0;
    acc_ready  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_acc_valid",  acc_valid,  0);
    chk("rst_busy",       busy,       0);
    chk("rst_acc",        acc,        0);
    chk("rst_ovf",        ovf,        0);
    rst_n = 1'b1;
    step();

    // 1: async reset in the middle of a frame
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    feed(32'sd1000);
    feed(32'sd2000);
    prod_valid = 1'b0;
    chk("t1_acc_before_rst", acc, 3000);
    rst_n = 1'b0;
    #1;
    chk("t1_busy_async",       busy,       0);
    chk("t1_prod_ready_async", prod_ready, 0);
    chk("t1_acc_async",        acc,        0);
    chk("t1_acc_valid_async",  acc_valid,  0);
    step();
    rst_n = 1'b1;
    step();

    // 2: len=4 back-to-back
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    chk("t2_busy",       busy,       1);
    chk("t2_prod_ready", prod_ready, 1);
    feed(-32'sd29952);
    feed(-32'sd296712);
    feed(32'sd422640);
    chk("t2_no_early_valid", acc_valid, 0);
    feed(32'sd85888);
    prod_valid = 1'b0;
    chk("t2_acc_valid",     acc_valid,  1);
    chk("t2_acc",           acc,        181864);
    chk("t2_prod_ready_dn", prod_ready, 0);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("t2_idle_busy",  busy,      0);
    chk("t2_idle_valid", acc_valid, 0);

    // 3: gaps on prod_valid, acc_ready held low 5 cycles
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    feed(-32'sd29952);
    idle_in();
    chk("t3_gap_ready", prod_ready, 1);
    feed(-32'sd296712);
    idle_in();
    idle_in();
    feed(32'sd422640);
    chk("t3_mid_acc", acc, 95976);
    feed(32'sd85888);
    // Keep offering a product in DONE: it must not be taken.
    prod       = 32'sd12345;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_acc",   acc,        181864);
      chk("t3_hold_valid", acc_valid,  1);
      chk("t3_hold_ready", prod_ready, 0);
      step();
    end
    prod_valid = 1'b0;
    acc_ready  = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("t3_handoff_busy", busy, 0);

    // 4: empty frame, start during DONE ignored
    start = 1'b1; len = 8'd0;
    step();
    chk("t4_valid", acc_valid, 1);
    chk("t4_acc",   acc,       0);
    len = 8'd3;
    step();
    start = 1'b0;
    chk("t4_still_done", acc_valid, 1);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("t4_not_queued", busy, 0);
    step();
    chk("t4_stay_idle", busy, 0);

    // 5: abort after 2 of 4 products, beating a same-cycle transfer
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    feed(32'sd500);
    feed(32'sd600);
    abort = 1'b1;
    feed(32'sd700);
    prod_valid = 1'b0;
    abort = 1'b0;
    chk("t5_abort_busy",  busy,      0);
    chk("t5_abort_valid", acc_valid, 0);
    chk("t5_abort_acc",   acc,       0);
    step();
    chk("t5_no_pulse", acc_valid, 0);
    // abort in IDLE blocks a simultaneous start
    abort = 1'b1; start = 1'b1; len = 8'd1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("t5_abort_idle_start", busy, 0);
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    feed(-32'sd7);
    prod_valid = 1'b0;
    chk("t5_len1_valid", acc_valid, 1);
    chk("t5_len1_acc",   acc,       -7);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;

    // 6: 8 x 2**30 into a 34-bit accumulator
    start = 1'b1; len = 8'd8;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(32'sd1073741824);
    end
    prod_valid = 1'b0;
    chk("t6_valid", acc_valid, 1);
    chk("t6_acc",   acc,       exp6_acc);
    chk("t6_ovf",   ovf,       exp6_ovf);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    // Next accepted start clears the sticky flag.
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    chk("t6_ovf_cleared", ovf, 0);
    chk("t6_next_acc",    acc, 0);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
